// File: rtl/pwm_update_ctrl_if.sv
// pwm_update_ctrl_if -- configuration request channel of pwm_update_ctrl.
//
// Signals:
//   cfg_valid  : requester has a request on cfg_ch/cfg_period/cfg_duty
//   cfg_ready  : controller takes the request on this rising edge
//   cfg_ch     : target channel index
//   cfg_period : requested period
//   cfg_duty   : requested duty
//   cfg_err    : one-cycle pulse, the previous handshake was rejected
//
// Handshake: a transfer happens on every rising edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is combinational from the controller
// state and cfg_ch; it does not depend on cfg_valid. The requester holds
// cfg_ch/cfg_period/cfg_duty stable while cfg_valid is 1 and cfg_ready is 0.
//
// Modports: master = requester, slave = pwm_update_ctrl.
interface pwm_update_ctrl_if #(
  parameter int CW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_ch;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_duty;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_duty,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl -- glitch-free period/duty update controller for a bank
// of PWM channels. Requests land in per-channel shadow registers and are
// copied to the active registers only at a safe point: immediately for a
// disabled channel, otherwise on the channel's own counter wrap, or on
// channel 0's wrap for all channels when sync_mode is set.
//
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   cfg        : configuration request channel (pwm_update_ctrl_if.slave)
//   ch_en      : per-channel enable
//   ch_wrap    : per-channel one-cycle pulse when its counter returns to 0
//   sync_mode  : commit every pending enabled channel on ch_wrap[0]
//   period_o   : active periods, channel i at [i*CW +: CW]
//   duty_o     : active duties, packed like period_o
//   pending_o  : channel FSM state (1 = PENDING), also the debug view
//   upd_done   : one-cycle pulse when a channel's active values change
module pwm_update_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_update_ctrl_if.slave     cfg,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    ch_wrap,
  input  logic                 sync_mode,
  output logic [NUM_CH*CW-1:0] period_o,
  output logic [NUM_CH*CW-1:0] duty_o,
  output logic [NUM_CH-1:0]    pending_o,
  output logic [NUM_CH-1:0]    upd_done
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

  ch_state_e     state_q [NUM_CH];
  ch_state_e     state_d [NUM_CH];
  logic [CW-1:0] shd_per_q  [NUM_CH];
  logic [CW-1:0] shd_duty_q [NUM_CH];
  logic [CW-1:0] act_per_q  [NUM_CH];
  logic [CW-1:0] act_duty_q [NUM_CH];

  logic              ch_in_range;
  logic              duty_ok;
  logic              cfg_ready_c;
  logic              accept;
  logic              reject;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] commit;
  logic [NUM_CH-1:0] upd_done_q;
  logic              cfg_err_q;

  // Out-of-range channels are always "ready" so the bad request is
  // consumed and reported instead of stalling the requester.
  always_comb begin
    ch_in_range = {1'b0, cfg.cfg_ch} < NUM_CH_L;
    duty_ok     = cfg.cfg_duty <= cfg.cfg_period;
    sel         = '0;
    cfg_ready_c = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (cfg.cfg_ch == 4'(i));
      if (sel[i]) cfg_ready_c = (state_q[i] == ST_IDLE);
    end
    accept = cfg.cfg_valid & cfg_ready_c;
    reject = accept & ~(ch_in_range & duty_ok);
  end

  assign cfg.cfg_ready = cfg_ready_c;

  // Next-state logic. load only fires from IDLE and commit only from
  // PENDING, so a request accepted on a wrap edge can never commit on
  // that same edge.
  always_comb begin
    load   = '0;
    commit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      load[i]    = accept & ch_in_range & duty_ok & sel[i];
      commit[i]  = (state_q[i] == ST_PENDING) &&
                   (!ch_en[i] || (sync_mode ? ch_wrap[0] : ch_wrap[i]));
      case (state_q[i])
        ST_IDLE:    if (load[i])   state_d[i] = ST_PENDING;
        ST_PENDING: if (commit[i]) state_d[i] = ST_IDLE;
        default:                   state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= ST_IDLE;
        shd_per_q[i]  <= '0;
        shd_duty_q[i] <= '0;
        act_per_q[i]  <= '0;
        act_duty_q[i] <= '0;
      end
      upd_done_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) begin
          shd_per_q[i]  <= cfg.cfg_period;
          shd_duty_q[i] <= cfg.cfg_duty;
        end
        if (commit[i]) begin
          act_per_q[i]  <= shd_per_q[i];
          act_duty_q[i] <= shd_duty_q[i];
        end
      end
      upd_done_q <= commit;
      cfg_err_q  <= reject;
    end
  end

  assign upd_done    = upd_done_q;
  assign cfg.cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign period_o[g*CW +: CW] = act_per_q[g];
    assign duty_o[g*CW +: CW]   = act_duty_q[g];
    assign pending_o[g]         = (state_q[g] == ST_PENDING);
  end

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// tb_pwm_update_ctrl -- directed bench for pwm_update_ctrl (NUM_CH=4, CW=16).
// Expected commits {ch, period, duty} are queued when a request is driven
// and retired when the matching upd_done bit is seen; the active-value
// model is updated from the retired entry and compared with the outputs.
module tb_pwm_update_ctrl;

  localparam int NUM_CH = 4;
  localparam int CW     = 16;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    ch_wrap;
  logic                 sync_mode;
  logic [NUM_CH*CW-1:0] period_o;
  logic [NUM_CH*CW-1:0] duty_o;
  logic [NUM_CH-1:0]    pending_o;
  logic [NUM_CH-1:0]    upd_done;

  pwm_update_ctrl_if #(.CW(CW)) cfg_if ();

  pwm_update_ctrl #(.NUM_CH(NUM_CH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if.slave),
    .ch_en     (ch_en),
    .ch_wrap   (ch_wrap),
    .sync_mode (sync_mode),
    .period_o  (period_o),
    .duty_o    (duty_o),
    .pending_o (pending_o),
    .upd_done  (upd_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [4+2*CW-1:0] exp_q[$];
  logic [CW-1:0]     mdl_per  [NUM_CH];
  logic [CW-1:0]     mdl_duty [NUM_CH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [NUM_CH*CW-1:0] ep;
    logic [NUM_CH*CW-1:0] ed;
    for (int c = 0; c < NUM_CH; c++) begin
      ep[c*CW +: CW] = mdl_per[c];
      ed[c*CW +: CW] = mdl_duty[c];
    end
    chk({tag, "_period"}, period_o, ep);
    chk({tag, "_duty"}, duty_o, ed);
  endtask

  // Advance one edge, sample 1ns later, retire any observed commits.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (upd_done[c]) begin
        int idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (idx < 0 && exp_q[k][4+2*CW-1 -: 4] == 4'(c)) idx = k;
        checks++;
        assert (idx >= 0) else begin
          errors++;
          $error("FAIL upd_done_unexpected ch=%0d observed=1 expected=0", c);
        end
        if (idx >= 0) begin
          mdl_per[c]  = exp_q[idx][2*CW-1 -: CW];
          mdl_duty[c] = exp_q[idx][CW-1:0];
          exp_q.delete(idx);
          chk("commit_period", 64'(period_o[c*CW +: CW]), 64'(mdl_per[c]));
          chk("commit_duty", 64'(duty_o[c*CW +: CW]), 64'(mdl_duty[c]));
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [3:0] ch, input logic [CW-1:0] p,
                      input logic [CW-1:0] d, input logic exp_ready);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_period = p;
    cfg_if.cfg_duty   = d;
    #1;
    chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(exp_ready));
    if (exp_ready && ch < 4'(NUM_CH) && d <= p) exp_q.push_back({ch, p, d});
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n             = 1'b0;
    ch_en             = 4'b1111;
    ch_wrap           = '0;
    sync_mode         = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mdl_per[c]  = '0;
      mdl_duty[c] = '0;
    end
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check_outs("reset");
    chk("reset_pending", 64'(pending_o), 64'(0));
    chk("reset_upd_done", 64'(upd_done), 64'(0));
    chk("reset_cfg_err", 64'(cfg_if.cfg_err), 64'(0));

    // basic enabled update, accepted on the first edge out of reset
    send(4'd1, 16'd99, 16'd25, 1'b1);
    for (int n = 0; n < 10; n++) begin
      chk("basic_pending", 64'(pending_o[1]), 64'(1));
      chk("basic_hold_period", 64'(period_o[CW +: CW]), 64'(0));
      tick();
    end
    ch_wrap = 4'b0010;
    tick();
    ch_wrap = '0;
    chk("basic_upd_done", 64'(upd_done), 64'(4'b0010));
    chk("basic_period", 64'(period_o[CW +: CW]), 64'(99));
    chk("basic_duty", 64'(duty_o[CW +: CW]), 64'(25));
    chk("basic_pending_clr", 64'(pending_o), 64'(0));
    tick();
    chk("basic_upd_done_once", 64'(upd_done), 64'(0));

    // backpressure on ch2, ch3 still accepted
    send(4'd2, 16'd200, 16'd100, 1'b1);
    send(4'd2, 16'd300, 16'd10, 1'b0);
    send(4'd3, 16'd80, 16'd40, 1'b1);
    chk("bp_pending", 64'(pending_o), 64'(4'b1100));
    ch_wrap = 4'b1100;
    tick();
    ch_wrap = '0;
    chk("bp_upd_done", 64'(upd_done), 64'(4'b1100));
    chk("bp_ch2_period", 64'(period_o[2*CW +: CW]), 64'(200));
    chk("bp_ch2_duty", 64'(duty_o[2*CW +: CW]), 64'(100));
    check_outs("bp");

    // disabled channel commits the cycle after acceptance
    ch_en = 4'b1110;
    send(4'd0, 16'd10, 16'd5, 1'b1);
    chk("dis_pending", 64'(pending_o), 64'(4'b0001));
    chk("dis_not_yet", 64'(period_o[0 +: CW]), 64'(0));
    tick();
    chk("dis_upd_done", 64'(upd_done), 64'(4'b0001));
    chk("dis_period", 64'(period_o[0 +: CW]), 64'(10));
    chk("dis_duty", 64'(duty_o[0 +: CW]), 64'(5));
    ch_en = 4'b1111;
    tick();

    // sync mode: only ch_wrap[0] commits, all together
    sync_mode = 1'b1;
    send(4'd1, 16'd11, 16'd1, 1'b1);
    send(4'd2, 16'd22, 16'd2, 1'b1);
    send(4'd3, 16'd33, 16'd3, 1'b1);
    ch_wrap = 4'b1110;
    tick();
    ch_wrap = '0;
    chk("sync_no_commit", 64'(upd_done), 64'(0));
    chk("sync_still_pending", 64'(pending_o), 64'(4'b1110));
    ch_wrap = 4'b0001;
    tick();
    ch_wrap = '0;
    chk("sync_upd_done", 64'(upd_done), 64'(4'b1110));
    chk("sync_ch3_period", 64'(period_o[3*CW +: CW]), 64'(33));
    check_outs("sync");
    sync_mode = 1'b0;
    tick();

    // errors: bad channel, duty > period, then duty == period accepted
    send(4'd5, 16'd1, 16'd1, 1'b1);
    chk("err_ch_pulse", 64'(cfg_if.cfg_err), 64'(1));
    chk("err_ch_pending", 64'(pending_o), 64'(0));
    check_outs("err_ch");
    tick();
    chk("err_ch_pulse_end", 64'(cfg_if.cfg_err), 64'(0));
    send(4'd1, 16'd40, 16'd50, 1'b1);
    chk("err_duty_pulse", 64'(cfg_if.cfg_err), 64'(1));
    chk("err_duty_pending", 64'(pending_o), 64'(0));
    check_outs("err_duty");
    send(4'd1, 16'd60, 16'd60, 1'b1);
    chk("eq_no_err", 64'(cfg_if.cfg_err), 64'(0));
    chk("eq_pending", 64'(pending_o), 64'(4'b0010));

    // request accepted on the same edge as its channel's wrap
    ch_wrap = 4'b0100;
    send(4'd2, 16'd70, 16'd35, 1'b1);
    ch_wrap = '0;
    chk("simul_pending", 64'(pending_o), 64'(4'b0110));
    chk("simul_no_done", 64'(upd_done), 64'(0));
    chk("simul_old_period", 64'(period_o[2*CW +: CW]), 64'(22));
    tick();
    chk("simul_still_no_done", 64'(upd_done), 64'(0));
    ch_wrap = 4'b0110;
    tick();
    ch_wrap = '0;
    chk("simul_upd_done", 64'(upd_done), 64'(4'b0110));
    chk("simul_ch2_period", 64'(period_o[2*CW +: CW]), 64'(70));
    check_outs("simul");

    // reset while pending discards the update
    send(4'd3, 16'd500, 16'd250, 1'b1);
    chk("rst_pre_pending", 64'(pending_o), 64'(4'b1000));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      mdl_per[c]  = '0;
      mdl_duty[c] = '0;
    end
    check_outs("rst_mid");
    chk("rst_mid_pending", 64'(pending_o), 64'(0));
    chk("rst_mid_upd_done", 64'(upd_done), 64'(0));
    ch_wrap = 4'b1000;
    tick();
    ch_wrap = '0;
    tick();
    chk("rst_no_late_done", 64'(upd_done), 64'(0));
    check_outs("rst_after_wrap");

    // random-valued disabled-channel updates after reset
    ch_en = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      logic [CW-1:0] p;
      logic [CW-1:0] d;
      p = CW'($urandom_range(1, 1000));
      d = CW'($urandom_range(0, int'(p)));
      send(4'(n), p, d, 1'b1);
      tick();
    end
    check_outs("rand");
    ch_en = 4'b1111;

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_update_ctrl.md
PWM_UPDATE_CTRL -- requirements
Module: pwm_update_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of PWM channels served (2..16).
REQ-002 The block SHALL have parameter CW, default 16, giving the period/duty width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port cfg_valid, input, 1, a configuration request is presented.
REQ-006 The block SHALL have port cfg_ready, output, 1, the request is accepted this cycle.
REQ-007 The block SHALL have port cfg_ch, input, 4, the target channel index.
REQ-008 The block SHALL have port cfg_period, input, CW, the requested period.
REQ-009 The block SHALL have port cfg_duty, input, CW, the requested duty.
REQ-010 The block SHALL have port ch_en, input, NUM_CH, per-channel enable.
REQ-011 The block SHALL have port ch_wrap, input, NUM_CH, a one-cycle pulse when that channel's counter returns to 0.
REQ-012 The block SHALL have port sync_mode, input, 1; when 1, all updates are committed on ch_wrap[0].
REQ-013 The block SHALL have port period_o, output, NUM_CH*CW, the active period per channel (channel i at bits [i*CW +: CW]).
REQ-014 The block SHALL have port duty_o, output, NUM_CH*CW, the active duty per channel, packed the same way as period_o.
REQ-015 The block SHALL have port pending_o, output, NUM_CH, a shadow update is waiting for that channel.
REQ-016 The block SHALL have port upd_done, output, NUM_CH, a one-cycle pulse when that channel's active values change.
REQ-017 The block SHALL have port cfg_err, output, 1, a one-cycle pulse when a request is rejected.

Function
REQ-018 Each channel SHALL hold shadow period/duty registers, active period/duty registers and a two-state FSM, IDLE or PENDING; pending_o[i] is 1 exactly when channel i is in PENDING.
REQ-019 cfg_ready SHALL be combinational:
- 1 when cfg_ch >= NUM_CH;
- otherwise the inverse of pending_o[cfg_ch].
REQ-020 A handshake (cfg_valid & cfg_ready) on a valid channel with cfg_duty <= cfg_period SHALL load the shadow registers and move that channel IDLE->PENDING at the same edge.
REQ-021 A handshake with cfg_ch >= NUM_CH or cfg_duty > cfg_period SHALL change no state and SHALL pulse cfg_err on the following cycle.
REQ-022 Commit condition for a PENDING channel i, evaluated each cycle with registered state:
- ch_en[i]=0: commit unconditionally (disabled channel, no glitch concern);
- ch_en[i]=1 and sync_mode=0: commit when ch_wrap[i]=1;
- ch_en[i]=1 and sync_mode=1: commit when ch_wrap[0]=1.
REQ-023 On commit, at the same edge:
- shadow values SHALL be copied to active;
- the channel SHALL go PENDING->IDLE;
- upd_done[i] SHALL be 1 for exactly the next cycle.
REQ-024 A request accepted in the same cycle a commit condition is true for that channel SHALL NOT commit in that cycle. The earliest commit is the cycle after acceptance (disabled channel) or the next qualifying wrap.
REQ-025 In sync_mode, all channels that are PENDING and enabled SHALL commit at the same edge, and their upd_done bits SHALL assert together.
REQ-026 A change of sync_mode or ch_en while PENDING SHALL take effect at the next evaluation; no request is lost or duplicated.
REQ-027 Channels SHALL be independent: activity on one channel SHALL NOT alter another channel's state, except through sync_mode.
REQ-028 period_o and duty_o SHALL be driven directly from the active registers, with no combinational path from cfg_* inputs.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL:
- set all channels to IDLE;
- clear shadow and active registers to 0 (period_o=0, duty_o=0);
- clear pending_o, upd_done and cfg_err to 0.
REQ-030 A reset asserted mid-PENDING SHALL discard the shadow update; no upd_done pulse occurs.
REQ-031 The first handshake SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-032 Basic enabled update: ch_en=4'b1111, sync_mode=0, send ch1 period=99 duty=25, then pulse ch_wrap[1] 10 cycles later -> pending_o[1]=1 for those 10 cycles; channel 1 of period_o/duty_o becomes 99/25 one cycle after the wrap; upd_done[1] pulses once.
REQ-033 Backpressure: while ch2 is PENDING, assert cfg_valid for ch2 -> cfg_ready=0 and the shadow is unchanged. Assert cfg_valid for ch3 in the same period -> accepted immediately.
REQ-034 Disabled channel: ch_en[0]=0, send ch0 period=10 duty=5 -> channel 0 active values are 10/5 on the cycle after acceptance; upd_done[0] pulses; no ch_wrap is needed.
REQ-035 Sync mode: sync_mode=1, update ch1, ch2 and ch3, pulse ch_wrap[1..3] (no effect), then ch_wrap[0] -> all three commit at the same edge, and upd_done=4'b1110 for one cycle.
REQ-036 Errors: cfg_ch=5 with NUM_CH=4, and separately duty=50 with period=40 -> cfg_ready=1, cfg_err pulses, and no output changes.
REQ-037 Reset and simultaneity: a request accepted on the same edge as ch_wrap for that channel -> no commit until the next wrap. rst_n=0 during PENDING -> period_o/duty_o=0, pending_o=0, and no upd_done pulse.
